// File: rtl/huff_pair_collector.sv
// Collects signed Huffman (x,y) pairs for one granule into a 576-entry buffer,
// then streams all frequency lines in index order. Optional clamp: HUFF_PAIR_SAT_EN.
module huff_pair_collector #(
  parameter int unsigned NUM_SAMPLES = 576,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned MAX_PAIRS   = 288
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8:0]          big_values,
  input  logic                pair_valid,
  input  logic [SAMPLE_W-1:0] x_val,
  input  logic [SAMPLE_W-1:0] y_val,
  output logic                collecting,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [9:0]          sample_idx,
  output logic                sample_last,
  output logic                done,
  output logic                err
);

  localparam int unsigned PAIR_W = 9;
  localparam int unsigned IDX_W  = 10;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [PAIR_W-1:0] PAIR_MAX  = PAIR_W'(MAX_PAIRS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PAIR_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [PAIR_W-1:0]   target_q, target_d;
  logic [IDX_W-1:0]    nz_q, nz_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                collecting_q, collecting_d;
  logic                valid_q, valid_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [SAMPLE_W-1:0] mem_q [NUM_SAMPLES];

  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr_x, wr_addr_y;
  logic [SAMPLE_W-1:0] wr_x, wr_y;
  logic                sat_hit;
  logic                rd_en;
  logic [IDX_W-1:0]    rd_addr, rd_lim;
  logic                over_big;
  logic [PAIR_W-1:0]   tgt;

  assign wr_addr_x = {pair_cnt_q, 1'b0};
  assign wr_addr_y = {pair_cnt_q, 1'b1};

`ifdef HUFF_PAIR_SAT_EN
  // Clamp to the largest legal decoded magnitude (15 + 2^13 - 1).
  localparam logic signed [SAMPLE_W-1:0] SAT_POS = SAMPLE_W'(8206);
  localparam logic signed [SAMPLE_W-1:0] SAT_NEG = -SAT_POS;
  logic x_hi, x_lo, y_hi, y_lo;
  assign x_hi    = $signed(x_val) > SAT_POS;
  assign x_lo    = $signed(x_val) < SAT_NEG;
  assign y_hi    = $signed(y_val) > SAT_POS;
  assign y_lo    = $signed(y_val) < SAT_NEG;
  assign wr_x    = x_hi ? SAT_POS : (x_lo ? SAT_NEG : x_val);
  assign wr_y    = y_hi ? SAT_POS : (y_lo ? SAT_NEG : y_val);
  assign sat_hit = x_hi | x_lo | y_hi | y_lo;
`else
  assign wr_x    = x_val;
  assign wr_y    = y_val;
  assign sat_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pair_cnt_d   = pair_cnt_q;
    target_d     = target_q;
    nz_d         = nz_q;
    idx_d        = idx_q;
    collecting_d = collecting_q;
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;
    done_d       = 1'b0;
    err_d        = err_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    rd_lim       = '0;
    over_big     = 1'b0;
    tgt          = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          over_big   = big_values > PAIR_MAX;
          tgt        = over_big ? PAIR_MAX : big_values;
          target_d   = tgt;
          pair_cnt_d = '0;
          nz_d       = '0;
          idx_d      = '0;
          err_d      = over_big;
          if (tgt == '0) begin
            state_d = S_DRAIN;
            valid_d = 1'b1;
            rd_en   = 1'b1;
          end else begin
            state_d      = S_COLLECT;
            collecting_d = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (pair_valid) begin
          wr_en      = 1'b1;
          pair_cnt_d = pair_cnt_q + PAIR_W'(1);
          if (sat_hit) err_d = 1'b1;
          if (pair_cnt_d == target_q) begin
            state_d      = S_DRAIN;
            collecting_d = 1'b0;
            nz_d         = {target_q, 1'b0};
            idx_d        = '0;
            valid_d      = 1'b1;
            rd_en        = 1'b1;
            rd_lim       = {target_q, 1'b0};
          end
        end
      end

      S_DRAIN: begin
        if (valid_q && sample_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            rd_en   = 1'b1;
            rd_addr = idx_d;
            rd_lim  = nz_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Pairs arriving outside COLLECT are dropped and flagged.
    if (pair_valid && (state_q != S_COLLECT)) err_d = 1'b1;

    // Fetch next sample; bypass covers the final pair being written this cycle.
    if (rd_en) begin
      last_d = (rd_addr == LAST_IDX);
      if (rd_addr >= rd_lim)                      data_d = '0;
      else if (wr_en && (rd_addr == wr_addr_x))   data_d = wr_x;
      else if (wr_en && (rd_addr == wr_addr_y))   data_d = wr_y;
      else                                        data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pair_cnt_q   <= '0;
      target_q     <= '0;
      nz_q         <= '0;
      idx_q        <= '0;
      collecting_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pair_cnt_q   <= pair_cnt_d;
      target_q     <= target_d;
      nz_q         <= nz_d;
      idx_q        <= idx_d;
      collecting_q <= collecting_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      last_q       <= last_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Sample buffer: no reset, contents survive across granules.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr_x] <= wr_x;
      mem_q[wr_addr_y] <= wr_y;
    end
  end

  assign collecting   = collecting_q;
  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign sample_idx   = idx_q;
  assign sample_last  = last_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_huff_pair_collector.sv
// Directed self-checking bench for huff_pair_collector; expectations follow
// HUFF_PAIR_SAT_EN when it is defined.
module tb_huff_pair_collector;

  localparam int NS = 576;

  logic        clk, rst, start, pair_valid, sample_ready;
  logic [8:0]  big_values;
  logic [15:0] x_val, y_val, sample_data;
  logic        collecting, sample_valid, sample_last, done, err;
  logic [9:0]  sample_idx;

  int checks = 0;
  int errors = 0;
  logic signed [15:0] exp_mem [NS];

  huff_pair_collector dut (
    .clk(clk), .rst(rst), .start(start), .big_values(big_values),
    .pair_valid(pair_valid), .x_val(x_val), .y_val(y_val),
    .collecting(collecting), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .sample_idx(sample_idx), .sample_last(sample_last),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NS; i++) exp_mem[i] = '0;
  endtask

  task automatic do_start(input logic [8:0] bv);
    start = 1'b1;
    big_values = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pair(input logic signed [15:0] x, input logic signed [15:0] y);
    pair_valid = 1'b1;
    x_val = x;
    y_val = y;
    @(negedge clk);
    pair_valid = 1'b0;
  endtask

  // Consumes one full drain starting at its first cycle; stall=1 uses ready 1,0,0,...
  task automatic drain(input string tag, input bit stall);
    int exp_idx = 0;
    int xfers = 0;
    int bad_v = 0, bad_i = 0, bad_d = 0, bad_l = 0, bad_done = 0;
    bit rdy;
    for (int cyc = 0; cyc < 3000 && xfers < NS; cyc++) begin
      if (sample_valid !== 1'b1) bad_v++;
      else begin
        if (sample_idx !== 10'(exp_idx)) bad_i++;
        if ($signed(sample_data) !== exp_mem[exp_idx]) bad_d++;
        if (sample_last !== (exp_idx == NS - 1)) bad_l++;
      end
      if (done !== 1'b0) bad_done++;
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      sample_ready = rdy;
      if (rdy && sample_valid === 1'b1) begin
        xfers++;
        exp_idx++;
      end
      @(negedge clk);
    end
    sample_ready = 1'b0;
    check({tag, "_xfers"},     xfers, NS);
    check({tag, "_valid_gap"}, bad_v, 0);
    check({tag, "_idx_bad"},   bad_i, 0);
    check({tag, "_data_bad"},  bad_d, 0);
    check({tag, "_last_bad"},  bad_l, 0);
    check({tag, "_early_done"}, bad_done, 0);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_valid_drop"}, sample_valid, 0);
    check({tag, "_idx_reset"},  sample_idx, 0);
    check({tag, "_last_clr"},   sample_last, 0);
    @(negedge clk);
    check({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; big_values = '0; pair_valid = 1'b0;
    x_val = '0; y_val = '0; sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_collecting", collecting, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_last", sample_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_data", sample_data, 0);
    check("rst_idx", sample_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: two pairs, ready always high
    clear_exp();
    exp_mem[0] = 3; exp_mem[1] = -1; exp_mem[2] = 0; exp_mem[3] = 7;
    do_start(9'd2);
    check("t1_collecting", collecting, 1);
    check("t1_idle_valid", sample_valid, 0);
    send_pair(16'sd3, -16'sd1);
    check("t1_mid_valid", sample_valid, 0);
    send_pair(16'sd0, 16'sd7);
    check("t1_valid_T1", sample_valid, 1);
    check("t1_collect_off", collecting, 0);
    check("t1_err", err, 0);
    drain("t1", 1'b0);

    // T2: zero pairs goes straight to drain
    clear_exp();
    do_start(9'd0);
    check("t2_collecting", collecting, 0);
    check("t2_valid_next", sample_valid, 1);
    check("t2_err", err, 0);
    drain("t2", 1'b0);

    // T3: one pair, stalled drain
    clear_exp();
    exp_mem[0] = -5; exp_mem[1] = 2;
    do_start(9'd1);
    send_pair(-16'sd5, 16'sd2);
    check("t3_valid", sample_valid, 1);
    check("t3_data0", $signed(sample_data), -5);
    drain("t3", 1'b1);

    // T4: big_values over range clamps to 288 and flags err
    clear_exp();
    for (int i = 0; i < 288; i++) begin
      exp_mem[2*i]   = 16'(i + 1);
      exp_mem[2*i+1] = 16'(-(i + 1));
    end
    do_start(9'd300);
    check("t4_err_set", err, 1);
    check("t4_collecting", collecting, 1);
    for (int i = 0; i < 288; i++) send_pair(16'(i + 1), 16'(-(i + 1)));
    check("t4_valid", sample_valid, 1);
    check("t4_collect_off", collecting, 0);
    sample_ready = 1'b0;
    send_pair(16'sd1000, 16'sd1000);
    check("t4_err_sticky", err, 1);
    check("t4_idx_hold", sample_idx, 0);
    check("t4_data_hold", $signed(sample_data), 1);
    start = 1'b1; big_values = 9'd5;
    @(negedge clk);
    start = 1'b0;
    check("t4_start_ignored_err", err, 1);
    check("t4_start_ignored_valid", sample_valid, 1);
    drain("t4", 1'b0);

    // T5: reset mid-collect abandons the granule
    do_start(9'd3);
    send_pair(16'sd11, 16'sd12);
    check("t5_collecting", collecting, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_collecting", collecting, 0);
    check("t5_rst_valid", sample_valid, 0);
    check("t5_rst_err", err, 0);
    check("t5_rst_idx", sample_idx, 0);
    check("t5_rst_data", sample_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle_valid", sample_valid, 0);
    check("t5_no_done", done, 0);
    clear_exp();
    exp_mem[0] = 9; exp_mem[1] = 9;
    do_start(9'd1);
    send_pair(16'sd9, 16'sd9);
    check("t5_valid", sample_valid, 1);
    drain("t5", 1'b0);

    // T6: large magnitudes (clamped only with saturation enabled)
    clear_exp();
`ifdef HUFF_PAIR_SAT_EN
    exp_mem[0] = 8206; exp_mem[1] = -8206;
`else
    exp_mem[0] = 9000; exp_mem[1] = -9000;
`endif
    do_start(9'd1);
    send_pair(16'sd9000, -16'sd9000);
`ifdef HUFF_PAIR_SAT_EN
    check("t6_err", err, 1);
`else
    check("t6_err", err, 0);
`endif
    drain("t6", 1'b0);
    send_pair(16'sd1, 16'sd1);
    check("t6_idle_pair_err", err, 1);
    check("t6_idle_no_valid", sample_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
